// File: rtl/mul_pkg.sv
// Shared definitions for the multicycle multiplier sequencer.
package mul_pkg;

    // Native operand width of the core's multiplier.
    localparam int MUL_WIDTH = 32;

    // Sequencer states: operand load, WIDTH shift-add steps, sign fix-up,
    // then one or two register-file write cycles.
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        WRLO,
        WRHI
    } state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: holds multiplicand, accumulator and shifted
// multiplier, and can negate the 2*WIDTH-bit product in place.
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               negate,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bsh;
    logic [WIDTH:0]   sum;

    // Add the multiplicand into the upper half when the current multiplier bit is set; carry is kept.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (bsh[0]) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a};
        end
    end

    // Load operands, then shift {carry, acc, bsh} right once per step; optional final negate.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; the operand/accumulator flops are also cleared
        // on reset so no stale product is visible after a reset.
        if (!rst_n) begin
            a   <= '0;
            acc <= '0;
            bsh <= '0;
        end else if (load) begin
            a   <= a_in;
            acc <= '0;
            bsh <= b_in;
        end else if (step) begin
            {acc, bsh} <= {sum, acc[WIDTH-1:0], bsh[WIDTH-1:1]};
        end else if (negate) begin
            acc <= -acc;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multicycle MUL/UMULL/SMULL unit: latches operands on Start, runs the
// shift-add datapath for WIDTH cycles, fixes the sign, then issues the
// low (and for long forms the high) register-file write with N/Z flags.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter  int WIDTH = MUL_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Long,
    input  logic             Signed,
    input  logic             Flush,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             WriteLo,
    output logic             WriteHi,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             FlagN,
    output logic             FlagZ
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic               long_q;
    logic               neg_q;
    logic               load;
    logic               step;
    logic               negate;
    logic               take_mag;
    logic               neg_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    // Signed long multiplies run on magnitudes; the sign is restored in FIX.
    assign take_mag = Signed & Long;
    assign neg_in   = take_mag & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
    assign mag_a    = (take_mag && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign mag_b    = (take_mag && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst_n  (reset),
        .load   (load),
        .step   (step),
        .negate (negate),
        .a_in   (mag_a),
        .b_in   (mag_b),
        .acc    (acc)
    );

    // State register, iteration counter and per-operation mode bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            long_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                count  <= '0;
                long_q <= Long;
                neg_q  <= neg_in;
            end else if (step) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Next-state decode, datapath controls and write strobes; Flush overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned (which would infer a latch).
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        negate     = 1'b0;
        Busy       = (state != IDLE);
        WriteLo    = 1'b0;
        WriteHi    = 1'b0;
        Done       = 1'b0;
        Result     = '0;

        case (state)
            IDLE: begin
                if (Start && !Flush) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (count == CNT_W'(WIDTH - 1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                negate     = neg_q;
                next_state = WRLO;
            end
            WRLO: begin
                WriteLo = 1'b1;
                Result  = acc[WIDTH-1:0];
                if (long_q) begin
                    next_state = WRHI;
                end else begin
                    Done       = 1'b1;
                    next_state = IDLE;
                end
            end
            WRHI: begin
                WriteHi    = 1'b1;
                Result     = acc[2*WIDTH-1:WIDTH];
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (Flush && state != IDLE) begin
            next_state = IDLE;
            step       = 1'b0;
            negate     = 1'b0;
            WriteLo    = 1'b0;
            WriteHi    = 1'b0;
            Done       = 1'b0;
            Result     = '0;
        end
    end

    // Flags reflect the full-width result and are only driven in the Done cycle.
    always_comb begin
        FlagN = 1'b0;
        FlagZ = 1'b0;
        if (Done) begin
            FlagN = long_q ? acc[2*WIDTH-1] : acc[WIDTH-1];
            FlagZ = long_q ? (acc == '0) : (acc[WIDTH-1:0] == '0);
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed scenarios plus random
// operations, each compared cycle by cycle against a 64-bit arithmetic model.
module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic         Long;
    logic         Signed;
    logic         Flush;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Busy;
    logic         WriteLo;
    logic         WriteHi;
    logic [W-1:0] Result;
    logic         Done;
    logic         FlagN;
    logic         FlagZ;

    int n_assert = 0;
    int n_fail   = 0;

    mul_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .Long    (Long),
        .Signed  (Signed),
        .Flush   (Flush),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .Busy    (Busy),
        .WriteLo (WriteLo),
        .WriteHi (WriteHi),
        .Result  (Result),
        .Done    (Done),
        .FlagN   (FlagN),
        .FlagZ   (FlagZ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_busy, input logic e_lo,
                             input logic e_hi, input logic e_done, input logic [W-1:0] e_res,
                             input logic e_n, input logic e_z);
        check({tag, " Busy"},    64'(Busy),    64'(e_busy));
        check({tag, " WriteLo"}, 64'(WriteLo), 64'(e_lo));
        check({tag, " WriteHi"}, 64'(WriteHi), 64'(e_hi));
        check({tag, " Done"},    64'(Done),    64'(e_done));
        check({tag, " Result"},  64'(Result),  64'(e_res));
        check({tag, " FlagN"},   64'(FlagN),   64'(e_n));
        check({tag, " FlagZ"},   64'(FlagZ),   64'(e_z));
    endtask

    // Architectural result: MUL keeps the low 32 bits, UMULL/SMULL the full 64.
    function automatic logic [63:0] ref_product(input bit lng, input bit sgn,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0]    lo;
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (!lng) begin
            lo = a * b;
            return {32'h0, lo};
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    // Start an operation (cycle 0) and check every cycle through Done, or through
    // the Flush cycle. Operands and mode inputs are scrambled after cycle 0.
    task automatic run_op(input string name, input bit lng, input bit sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int flush_at, input int restart_at);
        logic [63:0]  p;
        int           done_cyc;
        int           last;
        bit           fl;
        bit           e_lo;
        bit           e_hi;
        bit           e_done;
        logic [W-1:0] e_res;
        bit           e_n;
        bit           e_z;
        p        = ref_product(lng, sgn, a, b);
        done_cyc = lng ? 35 : 34;
        last     = (flush_at > 0 && flush_at < done_cyc) ? flush_at : done_cyc;

        @(posedge clk); #1;
        Start = 1'b1; Flush = 1'b0; Long = lng; Signed = sgn; SrcA = a; SrcB = b;
        @(negedge clk);
        check_all({name, " c0"}, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            Start  = (k == restart_at);
            Flush  = (k == flush_at);
            SrcA   = $urandom;
            SrcB   = $urandom;
            Long   = 1'($urandom);
            Signed = 1'($urandom);
            @(negedge clk);
            fl     = (k == flush_at);
            e_lo   = !fl && (k == 34);
            e_hi   = !fl && lng && (k == 35);
            e_done = !fl && (k == done_cyc);
            e_res  = e_lo ? p[31:0] : (e_hi ? p[63:32] : '0);
            e_n    = e_done && (lng ? p[63] : p[31]);
            e_z    = e_done && (lng ? (p == 64'h0) : (p[31:0] == 32'h0));
            check_all($sformatf("%s c%0d", name, k), 1'b1, e_lo, e_hi, e_done, e_res, e_n, e_z);
        end
    endtask

    initial begin
        bit lng;
        bit sgn;
        int fa;
        int ra;

        reset = 1'b0; Start = 1'b0; Long = 1'b0; Signed = 1'b0; Flush = 1'b0;
        SrcA = '0; SrcB = '0;
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Plain MUL.
        run_op("t1_mul_7x6", 1'b0, 1'b0, 32'd7, 32'd6, 0, 0);
        // UMULL with maximal operands exercises the adder carry.
        run_op("t2_umull_max", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        // Same operands, signed then unsigned long.
        run_op("t3_smull_m2x3", 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 0, 0);
        run_op("t3_umull_m2x3", 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        // Signed ignored for MUL.
        run_op("t3_mul_signed", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 0, 0);
        // Zero result, with a Start while busy that must be ignored.
        run_op("t4_mul_zero", 1'b0, 1'b0, 32'h0, 32'h1234_5678, 0, 10);
        // Signed corner: most negative squared.
        run_op("t_smull_corner", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        // Flush mid-CALC, then an immediate fresh Start.
        run_op("t5_flush", 1'b1, 1'b0, $urandom, $urandom, 20, 0);
        run_op("t5_after_flush", 1'b1, 1'b1, $urandom, $urandom, 0, 0);

        // Flush together with Start in IDLE: nothing starts.
        @(posedge clk); #1;
        Start = 1'b1; Flush = 1'b1; Long = 1'b1; Signed = 1'b0; SrcA = 32'd5; SrcB = 32'd5;
        @(negedge clk);
        check_all("flush_start_idle c0", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            Start = 1'b0; Flush = 1'b0;
            @(negedge clk);
            check_all($sformatf("flush_start_idle c%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of CALC, between clock edges.
        @(posedge clk); #1;
        Start = 1'b1; Flush = 1'b0; Long = 1'b1; Signed = 1'b0; SrcA = $urandom; SrcB = $urandom;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("t6_pre_reset Busy", 64'(Busy), 64'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        check_all("t6_async_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        run_op("t6_after_reset", 1'b1, 1'b1, $urandom, $urandom, 0, 0);

        // Random operations, some flushed, some with a stray Start while busy.
        for (int i = 0; i < 10; i++) begin
            lng = 1'($urandom);
            sgn = 1'($urandom);
            fa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 33)) : 0;
            ra  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 33)) : 0;
            run_op($sformatf("rand%0d", i), lng, sgn, $urandom, $urandom, fa, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
